mux_sel_scanner: RTL and testbench

- Sequencer that sits around the 4-to-1 select mux.
- Upstream, it drives the 2-bit select (sel[1] = s_1, sel[0] = s_0) through all four inputs.
- Downstream, it samples the mux output m once per slot and assembles the four bits into a parallel word for LEDs or later logic.
- Supports single-shot or continuous scanning, a pause input, and a done pulse per completed scan.

---
 rtl/mux_sel_scanner.sv | 137 +++++++++++++
 tb/tb_mux_sel_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux_sel_scanner                                                 |
// | Purpose  : Walks a 4:1 mux select and assembles its output into a word.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mux_sel_scanner #(
  parameter int DIV    = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic       hold,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] captured,
  output logic       busy,
  output logic       done,
  output logic [7:0] scan_count
);

  localparam logic [7:0] c_SETTLE = 8'(SETTLE);
  localparam logic [7:0] c_LAST   = 8'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tick;
  logic [1:0] r_sel;
  logic [3:0] r_shadow;
  logic [3:0] r_captured;
  logic [7:0] r_count;
  logic       w_sample;
  logic       w_slot_end;
  logic [3:0] w_shadow_next;

  // The shadow word including this edge's sample, so the last slot can be
  // forwarded straight into captured when SETTLE == DIV-1.
  always_comb begin
    w_sample      = (r_state == ST_DRIVE) && !hold && (r_tick == c_SETTLE);
    w_slot_end    = (r_state == ST_DRIVE) && !hold && (r_tick == c_LAST);
    w_shadow_next = r_shadow;
    if (w_sample) begin
      w_shadow_next[r_sel] = mux_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        busy = 1'b1;
        if (w_slot_end && (r_sel == 2'd3)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = continuous ? ST_DRIVE : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick     <= 8'd0;
      r_sel      <= 2'd0;
      r_shadow   <= 4'd0;
      r_captured <= 4'd0;
      r_count    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tick <= 8'd0;
            r_sel  <= 2'd0;
          end
        end
        ST_DRIVE: begin
          r_shadow <= w_shadow_next;
          if (!hold) begin
            if (r_tick == c_LAST) begin
              if (r_sel == 2'd3) begin
                r_captured <= w_shadow_next;
              end else begin
                r_sel  <= r_sel + 2'd1;
                r_tick <= 8'd0;
              end
            end else begin
              r_tick <= r_tick + 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_count <= r_count + 8'd1;
          r_tick  <= 8'd0;
          r_sel   <= 2'd0;
        end
        default: begin
          r_tick <= 8'd0;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign captured   = r_captured;
  assign scan_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mux_sel_scanner                                              |
// | Purpose  : Directed self-checking bench with a slot-position scan model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mux_sel_scanner;

  localparam int DIV    = 4;
  localparam int SETTLE = 1;
  localparam int SCAN   = 4 * DIV + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       continuous;
  logic       hold;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] captured;
  logic       busy;
  logic       done;
  logic [7:0] scan_count;

  logic [3:0] mux_in;
  logic       r_glitch;
  bit         glitch_en;
  int         total;
  int         bad;
  int         cyc;

  always #5 clk = ~clk;

  assign mux_out = mux_in[sel] ^ r_glitch;

  mux_sel_scanner #(.DIV(DIV), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .hold       (hold),
    .mux_out    (mux_out),
    .sel        (sel),
    .captured   (captured),
    .busy       (busy),
    .done       (done),
    .scan_count (scan_count)
  );

  // Model: 0 idle, 1 scanning at unheld position m_pos in 0..4*DIV-1, 2 done.
  int         m_st;
  int         m_pos;
  int         m_cnt;
  logic [3:0] m_shadow;
  logic [3:0] m_cap;
  logic [3:0] m_sh_nx;

  always_comb begin
    m_sh_nx = m_shadow;
    if (m_st == 1 && !hold && (m_pos % DIV) == SETTLE) begin
      m_sh_nx[2'(m_pos / DIV)] = mux_out;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_pos <= 0; m_cnt <= 0; m_shadow <= 4'd0; m_cap <= 4'd0;
    end else begin
      case (m_st)
        0: if (start) begin m_st <= 1; m_pos <= 0; end
        1: if (!hold) begin
          m_shadow <= m_sh_nx;
          if (m_pos == 4 * DIV - 1) begin
            m_cap <= m_sh_nx;
            m_st  <= 2;
          end else begin
            m_pos <= m_pos + 1;
          end
        end
        default: begin
          m_cnt <= (m_cnt + 1) % 256;
          if (continuous) begin m_st <= 1; m_pos <= 0; end
          else m_st <= 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Every cycle advance goes through here, so the model is compared each cycle.
  task automatic step;
    int e_sel;
    @(negedge clk);
    cyc++;
    e_sel = (m_st == 1) ? m_pos / DIV : ((m_st == 2) ? 3 : 0);
    chk("sel", 32'(sel), 32'(e_sel));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("done", 32'(done), 32'(m_st == 2));
    chk("captured", 32'(captured), 32'(m_cap));
    chk("scan_count", 32'(scan_count), 32'(m_cnt));
    r_glitch = glitch_en && (m_st == 1) && ((m_pos % DIV) != SETTLE);
  endtask

  task automatic single_scan(input int hold_cycles, input bit poke, input bit glitch,
                             output int lat);
    bit held;
    held      = 0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    glitch_en = glitch;
    lat       = 1;
    while (!done && lat < 200) begin
      if (hold_cycles > 0 && !held && m_st == 1 && m_pos == 2 * DIV + 1) begin
        hold = 1'b1;
        repeat (hold_cycles) begin step(); lat++; end
        hold = 1'b0;
        held = 1;
      end else begin
        start = (poke && lat == 6);
        step();
        lat++;
      end
    end
    start     = 1'b0;
    glitch_en = 0;
    chk("scan_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int ndone;
    int last;
    int budget;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; hold = 1'b0;
    mux_in = 4'b1010; r_glitch = 1'b0; glitch_en = 0;

    repeat (2) step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_captured", 32'(captured), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(scan_count), 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Plain scan of inputs 0,1,0,1.
    single_scan(0, 0, 0, lat);
    chk("lat_plain", 32'(lat), 32'd17);
    chk("cap_plain", 32'(captured), 32'b1010);
    step();
    chk("busy_after", 32'(busy), 32'd0);
    chk("count_1", 32'(scan_count), 32'd1);
    step();

    single_scan(5, 0, 0, lat);
    chk("lat_hold", 32'(lat), 32'd22);
    chk("cap_hold", 32'(captured), 32'b1010);
    repeat (2) step();

    // Start poke while busy, and mux_out flipped on non-sample ticks.
    single_scan(0, 1, 1, lat);
    chk("lat_poke", 32'(lat), 32'd17);
    chk("cap_glitch", 32'(captured), 32'b1010);
    repeat (2) step();
    chk("count_3", 32'(scan_count), 32'd3);

    // Continuous run of 260 scans with a mux input change after scan 100.
    continuous = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0; last = cyc - 1; budget = 0;
    while (ndone < 260 && budget < 260 * SCAN + 50) begin
      step();
      budget++;
      if (done) begin
        ndone++;
        chk("period", 32'(cyc - last), 32'(SCAN));
        chk("cnt_at_done", 32'(scan_count), 32'((3 + ndone - 1) % 256));
        last = cyc;
        if (ndone == 100) begin
          chk("cap_before_change", 32'(captured), 32'b1010);
          mux_in = 4'b0101;
        end
        if (ndone == 101) chk("cap_after_change", 32'(captured), 32'b0101);
        if (ndone == 253) chk("cnt_255", 32'(scan_count), 32'd255);
        if (ndone == 254) chk("cnt_wrap", 32'(scan_count), 32'd0);
        if (ndone == 259) begin
          step();
          continuous = 1'b0;
        end
      end
    end
    chk("cont_timeout", 32'(ndone), 32'd260);
    step();
    chk("idle_after_cont", 32'(busy), 32'd0);
    chk("count_wrapped", 32'(scan_count), 32'd7);
    step();

    // Reset in slot 3 after a scan capturing 0110.
    mux_in = 4'b0110;
    single_scan(0, 0, 0, lat);
    chk("cap_0110", 32'(captured), 32'b0110);
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while (!(m_st == 1 && m_pos >= 3 * DIV + 1) && budget < 40) begin
      step();
      budget++;
    end
    chk("reach_slot3", 32'(sel), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_captured", 32'(captured), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(scan_count), 32'd0);
    step();
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      step();
      if (done) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    chk("idle_after_rst", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
